// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered level, programmable almost-full/empty thresholds,
// write-through-when-full, flush and sticky overflow/underflow flags.
// Define SYNC_FIFO_REG_OUT_EN for a registered read-data stage; the default is show-ahead.
module sync_fifo_prog #(
    parameter int DATASIZE      = 8,
    parameter int DEPTH         = 16,
    parameter int PTR_WIDTH     = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_en,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                r_en,
    output logic [DATASIZE-1:0] data_out,
    output logic                rd_valid,
    input  logic                flush,
    input  logic                clear_flags,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic                fifo_almost_full,
    output logic                fifo_almost_empty,
    output logic [PTR_WIDTH:0]  fifo_level,
    output logic                fifo_overflow_flag,
    output logic                fifo_underflow_flag
);

    localparam logic [PTR_WIDTH:0] LEVEL_FULL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AFULL_L    = (PTR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [PTR_WIDTH:0] AEMPTY_L   = (PTR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [PTR_WIDTH:0] ONE        = (PTR_WIDTH + 1)'(1);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]  w_ptr;
    logic [PTR_WIDTH:0]  r_ptr;
    logic [PTR_WIDTH:0]  level;
    logic                rd_acc;
    logic                wr_acc;
    logic                ovf_set;
    logic                udf_set;

    // Status is decoded from the level register only, never from the request inputs.
    assign fifo_level        = level;
    assign fifo_full         = (level == LEVEL_FULL);
    assign fifo_empty        = (level == '0);
    assign fifo_almost_full  = (level >= AFULL_L);
    assign fifo_almost_empty = (level <= AEMPTY_L);

    assign rd_acc  = r_en & ~fifo_empty & ~flush;
    assign wr_acc  = w_en & (~fifo_full | rd_acc) & ~flush;
    assign ovf_set = w_en & ~wr_acc & ~flush;
    assign udf_set = r_en & ~rd_acc & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
        end else if (flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
        end else begin
            if (wr_acc) w_ptr <= w_ptr + ONE;
            if (rd_acc) r_ptr <= r_ptr + ONE;
            if (wr_acc && !rd_acc)      level <= level + ONE;
            else if (rd_acc && !wr_acc) level <= level - ONE;
        end
    end

    // A same-cycle set beats clear_flags so no dropped transfer goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_overflow_flag  <= 1'b0;
            fifo_underflow_flag <= 1'b0;
        end else if (flush) begin
            fifo_overflow_flag  <= 1'b0;
            fifo_underflow_flag <= 1'b0;
        end else begin
            if (ovf_set)          fifo_overflow_flag <= 1'b1;
            else if (clear_flags) fifo_overflow_flag <= 1'b0;
            if (udf_set)          fifo_underflow_flag <= 1'b1;
            else if (clear_flags) fifo_underflow_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[w_ptr[PTR_WIDTH-1:0]] <= data_in;
    end

`ifdef SYNC_FIFO_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) data_out <= mem[r_ptr[PTR_WIDTH-1:0]];
        end
    end
`else
    assign data_out = mem[r_ptr[PTR_WIDTH-1:0]];
    assign rd_valid = rd_acc;
`endif

endmodule
